// File: rtl/psum_mem_arbiter.sv
// Arbitrates a single-port partial-sum SRAM between controller reads, buffered
// controller write-backs (with read forwarding) and a low-priority host read port.
module psum_mem_arbiter #(
    parameter int unsigned ADDR_W            = 17,
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned WBUF_DEPTH        = 4,
    parameter int unsigned HOST_STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              ctrl_re,
    input  logic [ADDR_W-1:0] ctrl_raddr,
    output logic              ctrl_rvalid,
    output logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_we,
    input  logic [ADDR_W-1:0] ctrl_waddr,
    input  logic [DATA_W-1:0] ctrl_wdata,
    output logic              wbuf_almost_full,
    output logic              wbuf_overflow,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int unsigned PTR_W    = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = $clog2(HOST_STARVE_LIMIT + 1);

    logic [ADDR_W-1:0]   wb_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0]   wb_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [STARVE_W-1:0] starve_q;
    logic                overflow_q;

    logic                ctrl_rvalid_q, ctrl_fwd_q, host_rvalid_q, host_fwd_q;
    logic [DATA_W-1:0]   ctrl_fwd_data_q, host_fwd_data_q;
    logic [DATA_W-1:0]   ctrl_hold_q, host_hold_q;

    logic                ctrl_hit, host_hit;
    logic [DATA_W-1:0]   ctrl_fwd_data, host_fwd_data;
    logic                ctrl_sram, host_sram, pop, push, drop, wbuf_full;
    logic [PTR_W-1:0]    idx;

    // Youngest-match forwarding lookup over entries valid at the start of the cycle
    always_comb begin
        ctrl_hit      = 1'b0;
        host_hit      = 1'b0;
        ctrl_fwd_data = '0;
        host_fwd_data = '0;
        idx           = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (wb_addr_q[idx] == ctrl_raddr) begin
                    ctrl_hit      = 1'b1;
                    ctrl_fwd_data = wb_data_q[idx];
                end
                if (wb_addr_q[idx] == host_addr) begin
                    host_hit      = 1'b1;
                    host_fwd_data = wb_data_q[idx];
                end
            end
        end
    end

    // Per-cycle SRAM slot arbitration: ctrl read, starved host, drain, host
    always_comb begin
        host_gnt   = 1'b0;
        pop        = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        wbuf_full  = (count_q == CNT_W'(WBUF_DEPTH));
        ctrl_sram  = ctrl_re && !ctrl_hit;
        if (!ctrl_sram && host_req) begin
            if (starve_q >= STARVE_W'(HOST_STARVE_LIMIT) || count_q == '0) begin
                host_gnt = 1'b1;
            end
        end
        host_sram = host_gnt && !host_hit;
        pop       = !ctrl_sram && !host_sram && (count_q != '0);
        if (ctrl_sram) begin
            sram_ce   = 1'b1;
            sram_addr = ctrl_raddr;
        end else if (host_sram) begin
            sram_ce   = 1'b1;
            sram_addr = host_addr;
        end else if (pop) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = wb_addr_q[rd_ptr_q];
            sram_wdata = wb_data_q[rd_ptr_q];
        end
        push = ctrl_we && (!wbuf_full || pop);
        drop = ctrl_we && wbuf_full && !pop;
    end

    // Write-buffer payload storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wr_ptr_q] <= ctrl_waddr;
            wb_data_q[wr_ptr_q] <= ctrl_wdata;
        end
    end

    // Buffer pointers, occupancy, overflow flag and host starvation counter
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
            if (!host_req || host_gnt) begin
                starve_q <= '0;
            end else if (starve_q < STARVE_W'(HOST_STARVE_LIMIT)) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    // Read response pipeline: valid pulses, forward capture and held read data
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            ctrl_rvalid_q   <= 1'b0;
            ctrl_fwd_q      <= 1'b0;
            ctrl_fwd_data_q <= '0;
            ctrl_hold_q     <= '0;
            host_rvalid_q   <= 1'b0;
            host_fwd_q      <= 1'b0;
            host_fwd_data_q <= '0;
            host_hold_q     <= '0;
        end else begin
            ctrl_rvalid_q <= ctrl_re;
            ctrl_fwd_q    <= ctrl_re && ctrl_hit;
            if (ctrl_re && ctrl_hit) ctrl_fwd_data_q <= ctrl_fwd_data;
            if (ctrl_rvalid_q) ctrl_hold_q <= ctrl_rdata;
            host_rvalid_q <= host_gnt;
            host_fwd_q    <= host_gnt && host_hit;
            if (host_gnt && host_hit) host_fwd_data_q <= host_fwd_data;
            if (host_rvalid_q) host_hold_q <= host_rdata;
        end
    end

    assign ctrl_rvalid      = ctrl_rvalid_q;
    assign ctrl_rdata       = ctrl_rvalid_q ? (ctrl_fwd_q ? ctrl_fwd_data_q : sram_rdata) : ctrl_hold_q;
    assign host_rvalid      = host_rvalid_q;
    assign host_rdata       = host_rvalid_q ? (host_fwd_q ? host_fwd_data_q : sram_rdata) : host_hold_q;
    assign wbuf_almost_full = (count_q >= CNT_W'(WBUF_DEPTH - 1));
    assign wbuf_overflow    = overflow_q;
    assign busy             = (count_q != '0) || ctrl_rvalid_q || host_rvalid_q;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter with a behavioural single-port SRAM.
module tb_psum_mem_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b0;
    logic          ctrl_re = 1'b0;
    logic [AW-1:0] ctrl_raddr = '0;
    logic          ctrl_rvalid;
    logic [DW-1:0] ctrl_rdata;
    logic          ctrl_we = 1'b0;
    logic [AW-1:0] ctrl_waddr = '0;
    logic [DW-1:0] ctrl_wdata = '0;
    logic          wbuf_almost_full, wbuf_overflow;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int wr54_cnt = 0;
    int post_rst_wr = 0;
    bit post_rst_win = 1'b0;

    psum_mem_arbiter dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .ctrl_re(ctrl_re), .ctrl_raddr(ctrl_raddr),
        .ctrl_rvalid(ctrl_rvalid), .ctrl_rdata(ctrl_rdata),
        .ctrl_we(ctrl_we), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
        .wbuf_almost_full(wbuf_almost_full), .wbuf_overflow(wbuf_overflow),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: unwritten words hold a pattern derived from the address
    logic [DW-1:0] mem [256];
    bit            written [256];

    function automatic logic [DW-1:0] dflt(input logic [7:0] a);
        return (a == 8'h10) ? 32'h55 : (32'hC0DE_0000 | {24'h0, a});
    endfunction

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                mem[sram_addr[7:0]]     <= sram_wdata;
                written[sram_addr[7:0]] <= 1'b1;
                if (sram_addr == 17'h54) wr54_cnt++;
                if (post_rst_win) post_rst_wr++;
            end else begin
                sram_rdata <= written[sram_addr[7:0]] ? mem[sram_addr[7:0]] : dflt(sram_addr[7:0]);
            end
        end
    end

    typedef struct {
        logic          re;
        logic [AW-1:0] ra;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ce;
        logic          swe;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          crv;
        logic [DW-1:0] crd;
        logic [2:0]    flg;   // {almost_full, overflow, busy}
    } vec_t;

    function automatic vec_t v(input logic re, input logic [AW-1:0] ra, input logic we,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic ce, input logic swe, input logic [AW-1:0] sa,
                               input logic [DW-1:0] sd, input logic crv,
                               input logic [DW-1:0] crd, input logic [2:0] flg);
        vec_t r;
        r.re = re; r.ra = ra; r.we = we; r.wa = wa; r.wd = wd;
        r.ce = ce; r.swe = swe; r.sa = sa; r.sd = sd;
        r.crv = crv; r.crd = crd; r.flg = flg;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic hreq, input logic [AW-1:0] ha);
        ctrl_re = re; ctrl_raddr = ra; ctrl_we = we; ctrl_waddr = wa; ctrl_wdata = wd;
        host_req = hreq; host_addr = ha;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] sram_grp(input logic ce, input logic we,
                                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        return 128'({ce, we, a, d});
    endfunction

    vec_t tbl [23];

    initial begin
        tbl[0]  = v(0, 0,     0, 0,     0,      0, 0, 0,     0,      0, 0,            3'b000);
        tbl[1]  = v(1, 'h10,  0, 0,     0,      1, 0, 'h10,  0,      0, 0,            3'b000);
        tbl[2]  = v(0, 0,     0, 0,     0,      0, 0, 0,     0,      1, 'h55,         3'b001);
        tbl[3]  = v(0, 0,     1, 'h20,  'hAB,   0, 0, 0,     0,      0, 'h55,         3'b000);
        tbl[4]  = v(1, 'h20,  0, 0,     0,      1, 1, 'h20,  'hAB,   0, 'h55,         3'b001);
        tbl[5]  = v(0, 0,     0, 0,     0,      0, 0, 0,     0,      1, 'hAB,         3'b001);
        tbl[6]  = v(1, 'h11,  1, 'h30,  1,      1, 0, 'h11,  0,      0, 'hAB,         3'b000);
        tbl[7]  = v(1, 'h12,  1, 'h30,  2,      1, 0, 'h12,  0,      1, 'hC0DE0011,   3'b001);
        tbl[8]  = v(1, 'h30,  0, 0,     0,      1, 1, 'h30,  1,      1, 'hC0DE0012,   3'b001);
        tbl[9]  = v(0, 0,     0, 0,     0,      1, 1, 'h30,  2,      1, 2,            3'b001);
        tbl[10] = v(0, 0,     0, 0,     0,      0, 0, 0,     0,      0, 2,            3'b000);
        tbl[11] = v(1, 'h13,  1, 'h50,  'h500,  1, 0, 'h13,  0,      0, 2,            3'b000);
        tbl[12] = v(1, 'h14,  1, 'h51,  'h501,  1, 0, 'h14,  0,      1, 'hC0DE0013,   3'b001);
        tbl[13] = v(1, 'h15,  1, 'h52,  'h502,  1, 0, 'h15,  0,      1, 'hC0DE0014,   3'b001);
        tbl[14] = v(1, 'h16,  1, 'h53,  'h503,  1, 0, 'h16,  0,      1, 'hC0DE0015,   3'b101);
        tbl[15] = v(1, 'h17,  1, 'h54,  'h504,  1, 0, 'h17,  0,      1, 'hC0DE0016,   3'b101);
        tbl[16] = v(1, 'h18,  0, 0,     0,      1, 0, 'h18,  0,      1, 'hC0DE0017,   3'b111);
        tbl[17] = v(0, 0,     0, 0,     0,      1, 1, 'h50,  'h500,  1, 'hC0DE0018,   3'b111);
        tbl[18] = v(0, 0,     0, 0,     0,      1, 1, 'h51,  'h501,  0, 'hC0DE0018,   3'b111);
        tbl[19] = v(0, 0,     0, 0,     0,      1, 1, 'h52,  'h502,  0, 'hC0DE0018,   3'b011);
        tbl[20] = v(0, 0,     0, 0,     0,      1, 1, 'h53,  'h503,  0, 'hC0DE0018,   3'b011);
        tbl[21] = v(0, 0,     0, 0,     0,      0, 0, 0,     0,      0, 'hC0DE0018,   3'b010);
        tbl[22] = v(0, 0,     1, 'h60,  'h600,  0, 0, 0,     0,      0, 'hC0DE0018,   3'b010);

        // Reset with all inputs idle
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 128'({sram_ce, sram_we, sram_addr, sram_wdata, ctrl_rvalid, ctrl_rdata,
                                     host_gnt, host_rvalid, host_rdata, wbuf_almost_full,
                                     wbuf_overflow, busy}), 128'h0);
        arst_n_in = 1'b1;
        next_cycle();

        // Table: basic read, forwarding, youngest match, overflow
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, 0, 0);
            @(negedge clk);
            check($sformatf("v%0d_sram", i), sram_grp(sram_ce, sram_we, sram_addr, sram_wdata),
                  sram_grp(tbl[i].ce, tbl[i].swe, tbl[i].sa, tbl[i].sd));
            check($sformatf("v%0d_ctrl", i), 128'({ctrl_rvalid, ctrl_rdata}), 128'({tbl[i].crv, tbl[i].crd}));
            check($sformatf("v%0d_host", i), 128'({host_gnt, host_rvalid, host_rdata}), 128'h0);
            check($sformatf("v%0d_flags", i), 128'({wbuf_almost_full, wbuf_overflow, busy}), 128'(tbl[i].flg));
            next_cycle();
        end
        check("dropped_write_0x54", 128'(wr54_cnt), 128'h0);

        // Host starvation: buffer refilled every cycle so drain always wants the slot
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, AW'(32'h61 + k), DW'(32'h601 + k), 1, 'h40);
            @(negedge clk);
            check($sformatf("starve%0d_gnt", k), 128'(host_gnt), 128'h0);
            check($sformatf("starve%0d_sram", k), sram_grp(sram_ce, sram_we, sram_addr, sram_wdata),
                  sram_grp(1, 1, AW'(32'h60 + k), DW'(32'h600 + k)));
            next_cycle();
        end
        drive(0, 0, 1, 'h69, 'h609, 1, 'h40);
        @(negedge clk);
        check("starve_gnt", 128'(host_gnt), 128'h1);
        check("starve_gnt_sram", sram_grp(sram_ce, sram_we, sram_addr, sram_wdata), sram_grp(1, 0, 'h40, 0));
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("host_resp", 128'({host_gnt, host_rvalid, host_rdata}), 128'({1'b0, 1'b1, 32'hC0DE0040}));
        check("host_resp_drain", sram_grp(sram_ce, sram_we, sram_addr, sram_wdata), sram_grp(1, 1, 'h68, 'h608));
        next_cycle();
        @(negedge clk);
        check("host_hold", 128'({host_gnt, host_rvalid, host_rdata}), 128'({1'b0, 1'b0, 32'hC0DE0040}));
        check("host_last_drain", sram_grp(sram_ce, sram_we, sram_addr, sram_wdata), sram_grp(1, 1, 'h69, 'h609));
        next_cycle();
        @(negedge clk);
        check("host_idle_busy", 128'(busy), 128'h0);
        next_cycle();

        // Reset with three entries buffered (ctrl reads block the drain)
        for (int k = 0; k < 3; k++) begin
            drive(1, AW'(32'h19 + k), 1, AW'(32'h70 + k), DW'(32'h700 + k), 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("pre_reset_flags", 128'({wbuf_almost_full, wbuf_overflow, busy}), 128'(3'b111));
        @(negedge clk);
        arst_n_in = 1'b0;
        #1;
        check("mid_reset_flags", 128'({wbuf_almost_full, wbuf_overflow, busy}), 128'h0);
        check("mid_reset_sram", sram_grp(sram_ce, sram_we, sram_addr, sram_wdata), 128'h0);
        check("mid_reset_resp", 128'({ctrl_rvalid, ctrl_rdata, host_rvalid, host_rdata}), 128'h0);
        @(negedge clk);
        arst_n_in = 1'b1;
        post_rst_win = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        post_rst_win = 1'b0;
        check("post_reset_busy", 128'(busy), 128'h0);
        check("post_reset_writes", 128'(post_rst_wr), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
